i4004_bus_master: RTL

//  Initiator end of the 4-bit multiplexed MCS-4 bus: the CPU-side sequencer that the ROM/IO responders listen to.

---
 rtl/i4004_bus_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/i4004_bus_master.sv
// i4004_bus_master: initiator side of the 4-bit multiplexed MCS-4 bus.
// Runs the 8-phase machine cycle (A1 A2 A3 M1 M2 E1 E2 E3). It generates SYNC and CM,
// drives the fetch address, samples OPR/OPA, and performs the SRC/WRR/RDR execute transfers.
// Optional build macro I4004_BUS_WAIT_EN adds the hold input, which stretches E3 into wait states.
`ifndef OP_SRC
`define OP_SRC 4'h2
`endif
`ifndef OP_IOR
`define OP_IOR 4'hE
`endif
`ifndef FN_WRR
`define FN_WRR 4'h2
`endif
`ifndef FN_RDR
`define FN_RDR 4'hA
`endif

module i4004_bus_master #(
  parameter bit CM_ON_SRC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [3:0]  data,
  output logic        sync,
  output logic        cm,
  output logic [7:0]  phase,
  input  logic [11:0] pc,
  output logic        instr_valid,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  input  logic [7:0]  src_addr,
  input  logic [3:0]  wr_data,
  output logic [3:0]  rd_data,
  output logic        rd_valid
`ifdef I4004_BUS_WAIT_EN
  ,
  input  logic        hold
`endif
);

  localparam logic [7:0] PH_A1 = 8'h01;
  localparam logic [7:0] PH_A2 = 8'h02;
  localparam logic [7:0] PH_A3 = 8'h04;
  localparam logic [7:0] PH_M1 = 8'h08;
  localparam logic [7:0] PH_M2 = 8'h10;
  localparam logic [7:0] PH_E1 = 8'h20;
  localparam logic [7:0] PH_E2 = 8'h40;
  localparam logic [7:0] PH_E3 = 8'h80;

  logic [7:0]  ph_next;
  logic        stall;
  logic [11:4] addr_q;
  logic        src_pending;
  logic        data_oe;
  logic [3:0]  data_q;
  logic        drv_oe_d;
  logic [3:0]  drv_d;
  logic        cm_d;
  logic        is_src;
  logic        is_io;
  logic        is_wrr;
  logic        is_rdr;

  assign data = data_oe ? data_q : 'z;

  // Instruction decode from the latched OPR/OPA pair.
  always_comb begin
    is_src = (opr == `OP_SRC) && opa[0];
    is_io  = (opr == `OP_IOR);
    is_wrr = is_io && (opa == `FN_WRR) && src_pending;
    is_rdr = is_io && (opa == `FN_RDR) && src_pending;
  end

  // Phase ring successor; an illegal encoding falls back to E3 so the next cycle starts cleanly.
  always_comb begin
    stall = 1'b0;
`ifdef I4004_BUS_WAIT_EN
    stall = (phase == PH_E3) && hold;
`endif
    unique case (phase)
      PH_A1:   ph_next = PH_A2;
      PH_A2:   ph_next = PH_A3;
      PH_A3:   ph_next = PH_M1;
      PH_M1:   ph_next = PH_M2;
      PH_M2:   ph_next = PH_E1;
      PH_E1:   ph_next = PH_E2;
      PH_E2:   ph_next = PH_E3;
      PH_E3:   ph_next = stall ? PH_E3 : PH_A1;
      default: ph_next = PH_E3;
    endcase
  end

  // Bus drive and CM for the phase being entered.
  // Outputs are computed one phase early so every pin change lands exactly on a clk edge.
  always_comb begin
    drv_oe_d = 1'b0;
    drv_d    = '0;
    cm_d     = 1'b0;
    if (phase == PH_E3 && !stall) begin
      drv_oe_d = 1'b1;
      drv_d    = pc[3:0];
    end
    if (phase == PH_A1) begin
      drv_oe_d = 1'b1;
      drv_d    = addr_q[7:4];
    end
    if (phase == PH_A2) begin
      drv_oe_d = 1'b1;
      drv_d    = addr_q[11:8];
      cm_d     = 1'b1;
    end
    // OPR is sampled on this same edge, so the M2 strobe looks at the bus directly.
    if (phase == PH_M1)
      cm_d = (data == `OP_IOR) && src_pending;
    if (phase == PH_E1) begin
      if (is_src) begin
        drv_oe_d = 1'b1;
        drv_d    = src_addr[7:4];
        cm_d     = CM_ON_SRC;
      end else if (is_wrr) begin
        drv_oe_d = 1'b1;
        drv_d    = wr_data;
      end
    end
    if (phase == PH_E2 && is_src) begin
      drv_oe_d = 1'b1;
      drv_d    = src_addr[3:0];
    end
  end

  // Sequencer state, fetch/readback latches and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase       <= PH_E3;
      sync        <= 1'b0;
      cm          <= 1'b0;
      data_oe     <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      src_pending <= 1'b0;
      opr         <= '0;
      opa         <= '0;
      rd_data     <= '0;
      instr_valid <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      phase       <= ph_next;
      sync        <= (ph_next == PH_E3);
      cm          <= cm_d;
      data_oe     <= drv_oe_d;
      data_q      <= drv_d;
      instr_valid <= (phase == PH_M2);
      rd_valid    <= (phase == PH_E2) && is_rdr;
      if (phase == PH_E3 && !stall) begin
        addr_q      <= pc[11:4];
        src_pending <= is_src;
      end
      if (phase == PH_M1)
        opr <= data;
      if (phase == PH_M2)
        opa <= data;
      if (phase == PH_E2 && is_rdr)
        rd_data <= data;
    end
  end

endmodule
